// File: rtl/bcd_updown_chain.sv
// Multi-digit BCD up/down counter with a per-digit modulus, parallel load,
// and combinational carry/borrow strobes for cascading instances.

// One BCD digit: holds its own state, clamps loads, and steps on carry/borrow.
module bcd_updown_digit #(
   parameter int MOD = 10
) (
   input  logic       clk_out,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic       carry,
   input  logic       borrow,
   output logic [3:0] digit,
   output logic       at_max,
   output logic       at_zero
);

   localparam logic [3:0] MAXD = 4'(MOD - 1);

   assign at_max  = (digit == MAXD);
   assign at_zero = (digit == 4'd0);

   // Digit register: load (clamped) wins, otherwise step up/down on the incoming ripple.
   always_ff @(posedge clk_out or posedge rst) begin
      if (rst)
         digit <= 4'd0;
      else if (load)
         digit <= (load_digit > MAXD) ? MAXD : load_digit;
      else if (carry)
         digit <= at_max ? 4'd0 : digit + 4'd1;
      else if (borrow)
         digit <= at_zero ? MAXD : digit - 4'd1;
   end

endmodule

module bcd_updown_chain #(
   parameter int                    DIGITS   = 2,
   parameter logic [4*DIGITS-1:0]   MOD_LIST = 8'h6A,
   parameter bit                    WRAP     = 1'b1
) (
   input  logic                  clk_out,
   input  logic                  rst,
   input  logic                  increase,
   input  logic                  decrease,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   output logic [4*DIGITS-1:0]   value,
   output logic                  over,
   output logic                  under,
   output logic                  is_zero
);

   logic                inc_req;
   logic                dec_req;
   logic                all_max;
   logic                all_zero;
   logic                freeze;
   logic [DIGITS-1:0]   at_max;
   logic [DIGITS-1:0]   at_zero;
   logic [DIGITS-1:0]   carry;
   logic [DIGITS-1:0]   borrow;

   // Load dominates; simultaneous up and down cancel out.
   assign inc_req  = increase & ~decrease & ~load;
   assign dec_req  = decrease & ~increase & ~load;

   assign all_max  = &at_max;
   assign all_zero = &at_zero;

   assign over     = inc_req & all_max;
   assign under    = dec_req & all_zero;
   assign is_zero  = all_zero;

   // In saturating mode the overflowing/underflowing step is suppressed entirely,
   // so the ripple never starts and every digit holds.
   assign freeze   = ~WRAP & (over | under);

   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_digit
         if (i == 0) begin : g_first
            assign carry[i]  = inc_req & ~freeze;
            assign borrow[i] = dec_req & ~freeze;
         end else begin : g_rest
            assign carry[i]  = carry[i-1]  & at_max[i-1];
            assign borrow[i] = borrow[i-1] & at_zero[i-1];
         end

         bcd_updown_digit #(
            .MOD (int'(MOD_LIST[4*i +: 4]))
         ) u_digit (
            .clk_out    (clk_out),
            .rst        (rst),
            .load       (load),
            .load_digit (load_value[4*i +: 4]),
            .carry      (carry[i]),
            .borrow     (borrow[i]),
            .digit      (value[4*i +: 4]),
            .at_max     (at_max[i]),
            .at_zero    (at_zero[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_bcd_updown_chain.sv
// Scoreboard bench: stimulus pushes expected outputs for the current cycle,
// a monitor pops and compares at the falling edge.
module tb_bcd_updown_chain;

   typedef struct {
      string       name;
      bit          sel;
      logic [15:0] v;
      logic        ov;
      logic        un;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   logic        clk_out = 1'b0;
   logic        rst;

   logic        a_inc, a_dec, a_ld;
   logic [7:0]  a_lv, a_val;
   logic        a_ov, a_un, a_z;

   logic        b_inc, b_dec, b_ld;
   logic [15:0] b_lv, b_val;
   logic        b_ov, b_un, b_z;

   always #5 clk_out = ~clk_out;

   bcd_updown_chain dut_a (
      .clk_out    (clk_out),
      .rst        (rst),
      .increase   (a_inc),
      .decrease   (a_dec),
      .load       (a_ld),
      .load_value (a_lv),
      .value      (a_val),
      .over       (a_ov),
      .under      (a_un),
      .is_zero    (a_z)
   );

   bcd_updown_chain #(
      .DIGITS   (4),
      .MOD_LIST (16'hAAAA),
      .WRAP     (1'b0)
   ) dut_b (
      .clk_out    (clk_out),
      .rst        (rst),
      .increase   (b_inc),
      .decrease   (b_dec),
      .load       (b_ld),
      .load_value (b_lv),
      .value      (b_val),
      .over       (b_ov),
      .under      (b_un),
      .is_zero    (b_z)
   );

   // Drive one cycle of dut_a and record the outputs expected before the next edge.
   task automatic step_a(input string nm, input logic r, input logic inc, input logic dec,
                         input logic ld, input logic [7:0] lv,
                         input logic [7:0] ev, input logic eov, input logic eun);
      exp_t e;
      @(posedge clk_out); #1;
      rst = r; a_inc = inc; a_dec = dec; a_ld = ld; a_lv = lv;
      e.name = nm; e.sel = 1'b0; e.v = {8'h00, ev}; e.ov = eov; e.un = eun;
      q.push_back(e);
   endtask

   task automatic step_b(input string nm, input logic inc, input logic dec,
                         input logic ld, input logic [15:0] lv,
                         input logic [15:0] ev, input logic eov, input logic eun);
      exp_t e;
      @(posedge clk_out); #1;
      b_inc = inc; b_dec = dec; b_ld = ld; b_lv = lv;
      e.name = nm; e.sel = 1'b1; e.v = ev; e.ov = eov; e.un = eun;
      q.push_back(e);
   endtask

   // Monitor: compare whatever the stimulus queued for this cycle.
   initial begin
      exp_t e;
      logic [15:0] av;
      logic        aov, aun, az, ez;
      forever begin
         @(negedge clk_out);
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.sel) begin
               av = b_val; aov = b_ov; aun = b_un; az = b_z;
            end else begin
               av = {8'h00, a_val}; aov = a_ov; aun = a_un; az = a_z;
            end
            ez = (e.v == 16'h0000);
            checks++;
            if (av !== e.v || aov !== e.ov || aun !== e.un || az !== ez) begin
               failures++;
               $display("FAIL %s: got value=%h over=%b under=%b is_zero=%b, want value=%h over=%b under=%b is_zero=%b",
                        e.name, av, aov, aun, az, e.v, e.ov, e.un, ez);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      a_inc = 0; a_dec = 0; a_ld = 0; a_lv = '0;
      b_inc = 0; b_dec = 0; b_ld = 0; b_lv = '0;
      repeat (2) @(posedge clk_out);

      //      name            rst inc dec ld  lv      exp   ov un
      step_a("reset_state",   0,  0,  0,  0,  8'h00,  8'h00, 0, 0);
      step_a("load42",        0,  0,  0,  1,  8'h42,  8'h00, 0, 0);
      step_a("hold42",        0,  0,  0,  0,  8'h00,  8'h42, 0, 0);
      step_a("rst_async",     1,  0,  0,  0,  8'h00,  8'h00, 0, 0);
      step_a("rst_release",   0,  0,  0,  0,  8'h00,  8'h00, 0, 0);
      step_a("load58",        0,  0,  0,  1,  8'h58,  8'h00, 0, 0);
      step_a("inc58",         0,  1,  0,  0,  8'h00,  8'h58, 0, 0);
      step_a("inc59_over",    0,  1,  0,  0,  8'h00,  8'h59, 1, 0);
      step_a("wrap_to_00",    0,  0,  0,  0,  8'h00,  8'h00, 0, 0);
      step_a("dec00_under",   0,  0,  1,  0,  8'h00,  8'h00, 0, 1);
      step_a("wrap_to_59",    0,  0,  0,  0,  8'h00,  8'h59, 0, 0);
      step_a("load30",        0,  0,  0,  1,  8'h30,  8'h59, 0, 0);
      step_a("dec30",         0,  0,  1,  0,  8'h00,  8'h30, 0, 0);
      step_a("borrow_29",     0,  0,  0,  0,  8'h00,  8'h29, 0, 0);
      step_a("load59",        0,  0,  0,  1,  8'h59,  8'h29, 0, 0);
      step_a("load37_inc",    0,  1,  0,  1,  8'h37,  8'h59, 0, 0);
      step_a("hold37",        0,  0,  0,  0,  8'h00,  8'h37, 0, 0);
      step_a("load7C",        0,  0,  0,  1,  8'h7C,  8'h37, 0, 0);
      step_a("clamp59",       0,  0,  0,  0,  8'h00,  8'h59, 0, 0);
      step_a("incdec59",      0,  1,  1,  0,  8'h00,  8'h59, 0, 0);
      step_a("incdec_hold",   0,  0,  0,  0,  8'h00,  8'h59, 0, 0);
      step_a("load00",        0,  0,  0,  1,  8'h00,  8'h59, 0, 0);
      step_a("load05_dec",    0,  0,  1,  1,  8'h05,  8'h00, 0, 0);
      step_a("hold05",        0,  0,  0,  0,  8'h00,  8'h05, 0, 0);

      //      name            inc dec ld  lv        exp       ov un
      step_b("b_reset",       0,  0,  0,  16'h0000, 16'h0000, 0, 0);
      step_b("b_load9999",    0,  0,  1,  16'h9999, 16'h0000, 0, 0);
      step_b("b_inc_sat",     1,  0,  0,  16'h0000, 16'h9999, 1, 0);
      step_b("b_hold_max",    0,  0,  0,  16'h0000, 16'h9999, 0, 0);
      step_b("b_load0000",    0,  0,  1,  16'h0000, 16'h9999, 0, 0);
      step_b("b_dec_sat",     0,  1,  0,  16'h0000, 16'h0000, 0, 1);
      step_b("b_hold_zero",   0,  0,  0,  16'h0000, 16'h0000, 0, 0);
      step_b("b_inc0",        1,  0,  0,  16'h0000, 16'h0000, 0, 0);
      step_b("b_val1",        0,  0,  0,  16'h0000, 16'h0001, 0, 0);
      step_b("b_load1000",    0,  0,  1,  16'h1000, 16'h0001, 0, 0);
      step_b("b_dec1000",     0,  1,  0,  16'h0000, 16'h1000, 0, 0);
      step_b("b_ripple0999",  0,  0,  0,  16'h0000, 16'h0999, 0, 0);

      repeat (3) @(posedge clk_out);
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL queue_drain: got %0d pending entries, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
